// File: rtl/decode_queue_stage_if.sv
// -----------------------------------------------------------------------------
// decode_queue_stage_if
// Purpose : groups the frontend push side, the issue pop side, the flush input
//           and the decoded head fields of the decode queue into one bundle.
// Ports   : frontend -> in_valid/in_ready/in_pc/in_instr/in_misaligned
//           commit   -> flush
//           issue    -> out_valid/out_ready plus decoded head fields
//                       (pc, opcode, rd, rs1, rs2, funct3, funct7, imm,
//                       misaligned, illegal_instr) and occupancy count
// Modports: master = environment driving the queue, slave = the queue itself
// -----------------------------------------------------------------------------
interface decode_queue_stage_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;
  logic            in_misaligned;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] pc;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;
  logic            misaligned;
  logic            illegal_instr;
  logic [CW-1:0]   count;

  modport master (
    output in_valid, in_pc, in_instr, in_misaligned, flush, out_ready,
    input  in_ready, out_valid, pc, opcode, rd, rs1, rs2, funct3, funct7,
           imm, misaligned, illegal_instr, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, in_misaligned, flush, out_ready,
    output in_ready, out_valid, pc, opcode, rd, rs1, rs2, funct3, funct7,
           imm, misaligned, illegal_instr, count
  );
endinterface

// File: rtl/decode_queue_stage.sv
// -----------------------------------------------------------------------------
// decode_queue_stage
// Purpose : DEPTH-entry instruction queue between fetch and issue with
//           valid/ready on both sides, synchronous flush, and field/immediate
//           decode of the head entry.
// Ports   : clk  - rising-edge clock
//           nrst - asynchronous active-low reset (empties queue, clears storage)
//           bus  - decode_queue_stage_if.slave (push side, pop side, flush,
//                  decoded head fields, occupancy)
// -----------------------------------------------------------------------------
module decode_queue_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 nrst,
  decode_queue_stage_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // Immediate built as a 32-bit sign-extended value, then widened to XLEN.
  function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] ins);
    logic [31:0] v;
    case (ins[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
        v = {{20{ins[31]}}, ins[31:20]};
      OP_STORE:
        v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OP_BRANCH:
        v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        v = {ins[31:12], 12'b0};
      OP_JAL:
        v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:
        v = 32'd0;
    endcase
    return XLEN'($signed(v));
  endfunction

  function automatic logic op_supported(input logic [6:0] op);
    logic ok;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH,
      OP_LUI, OP_AUIPC, OP_JAL, OP_REG, OP_FENCE: ok = 1'b1;
      default:                                     ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [XLEN-1:0]  r_pc    [DEPTH];
  logic [31:0]      r_instr [DEPTH];
  logic [DEPTH-1:0] r_mis;
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_count;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_head_instr;

  // Handshake flags come only from the registered occupancy.
  assign w_in_ready  = (r_count != FULL_CNT);
  assign w_out_valid = (r_count != {CW{1'b0}});
  assign w_push      = bus.in_valid & w_in_ready & ~bus.flush;
  assign w_pop       = w_out_valid & bus.out_ready & ~bus.flush;

  // Entry storage: written at the write pointer on an accepted push.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= {XLEN{1'b0}};
        r_instr[i] <= 32'd0;
      end
      r_mis <= {DEPTH{1'b0}};
    end else if (w_push) begin
      r_pc[r_wp]    <= bus.in_pc;
      r_instr[r_wp] <= bus.in_instr;
      r_mis[r_wp]   <= bus.in_misaligned;
    end else begin
      r_mis <= r_mis;
    end
  end

  // Pointers and occupancy; flush wins over any same-cycle push/pop.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wp    <= {AW{1'b0}};
      r_rp    <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
    end else if (bus.flush) begin
      r_wp    <= {AW{1'b0}};
      r_rp    <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      else        r_wp <= r_wp;
      if (w_pop)  r_rp <= r_rp + AW'(1);
      else        r_rp <= r_rp;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head_instr = r_instr[r_rp];

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = w_out_valid;
  assign bus.count         = r_count;
  assign bus.pc            = r_pc[r_rp];
  assign bus.opcode        = w_head_instr[6:0];
  assign bus.rd            = w_head_instr[11:7];
  assign bus.funct3        = w_head_instr[14:12];
  assign bus.rs1           = w_head_instr[19:15];
  assign bus.rs2           = w_head_instr[24:20];
  assign bus.funct7        = w_head_instr[31:25];
  assign bus.imm           = imm_gen(w_head_instr);
  assign bus.misaligned    = r_mis[r_rp];
  // Gated by out_valid so an empty queue never reports an illegal opcode.
  assign bus.illegal_instr = w_out_valid & ~op_supported(w_head_instr[6:0]);
endmodule
